// File: rtl/cim_sched_pkg.sv
// Shared types for the CIM layer scheduler: per-layer state enum and default counter width.
package cim_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CIM_START = 3'd1,
    ST_CIM_WAIT  = 3'd2,
    ST_FUNC_WAIT = 3'd3,
    ST_FUNC_RUN  = 3'd4
  } layer_state_t;

  // A slot is occupied while an image is queued for it or being processed by it.
  function automatic logic is_occupied(input logic token, input layer_state_t st);
    return token || (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/layer_slot_fsm.sv
// Sequencer for one CIM layer: start pulse, CIM-phase tracking, function-phase handshake.
//   state        | meaning
//   ST_IDLE      | no image; waits for the slot token
//   ST_CIM_START | o_start pulse to the layer
//   ST_CIM_WAIT  | waits for busy to be seen high, then low
//   ST_FUNC_WAIT | CIM done; waits for downstream to be free
//   ST_FUNC_RUN  | function/output phase running; waits for done
module layer_slot_fsm
  import cim_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_token,
  input  logic         i_busy,
  input  logic         i_done,
  input  logic         i_next_busy,
  output logic         o_take,
  output logic         o_start,
  output logic         o_func_start,
  output logic         o_done_ok,
  output layer_state_t o_state
);

  layer_state_t r_state;
  layer_state_t w_state_nxt;
  logic         r_busy_seen;
  logic         w_busy_seen_nxt;
  logic         r_func_start;
  logic         w_func_start_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_busy_seen  <= 1'b0;
      r_func_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy_seen  <= w_busy_seen_nxt;
      r_func_start <= w_func_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_busy_seen_nxt  = r_busy_seen;
    w_func_start_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_token) w_state_nxt = ST_CIM_START;
      end
      ST_CIM_START: begin
        w_busy_seen_nxt = 1'b0;
        w_state_nxt     = ST_CIM_WAIT;
      end
      ST_CIM_WAIT: begin
        // Busy must rise and fall inside this state; a low busy before the rise is not completion.
        if (r_busy_seen && !i_busy) w_state_nxt = ST_FUNC_WAIT;
        else if (i_busy)            w_busy_seen_nxt = 1'b1;
      end
      ST_FUNC_WAIT: begin
        if (!i_next_busy) begin
          w_state_nxt      = ST_FUNC_RUN;
          w_func_start_nxt = 1'b1;
        end
      end
      ST_FUNC_RUN: begin
        if (i_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_take       = (r_state == ST_IDLE) && i_token;
  assign o_start      = (r_state == ST_CIM_START);
  assign o_func_start = r_func_start;
  assign o_done_ok    = (r_state == ST_FUNC_RUN) && i_done;
  assign o_state      = r_state;

endmodule

// File: rtl/layer_sched.sv
// Token-passing scheduler chaining NUM_LAYERS CIM layers with downstream back-pressure.
// Define LAYER_SCHED_PERF_EN to add per-layer FUNC_WAIT stall counters (o_stall_cnt).
module layer_sched
  import cim_sched_pkg::*;
#(
  parameter int NUM_LAYERS = 5,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [NUM_LAYERS-1:0] i_layer_busy,
  input  logic [NUM_LAYERS-1:0] i_layer_done,
  output logic [NUM_LAYERS-1:0] o_start,
  output logic [NUM_LAYERS-1:0] o_func_start,
  output logic [NUM_LAYERS-1:0] o_next_busy,
  input  logic                  i_out_stall,
  output logic                  o_out_valid,
`ifdef LAYER_SCHED_PERF_EN
  output logic [NUM_LAYERS-1:0][CNT_W-1:0] o_stall_cnt,
`endif
  output logic [CNT_W-1:0]      o_img_cnt
);

  logic [NUM_LAYERS-1:0] r_token;
  logic [NUM_LAYERS-1:0] w_take;
  logic [NUM_LAYERS-1:0] w_tok_set;
  logic [NUM_LAYERS-1:0] w_done_ok;
  logic [NUM_LAYERS-1:0] w_occ;
  layer_state_t          w_state [NUM_LAYERS];
  logic                  r_out_valid;
  logic [CNT_W-1:0]      r_img_cnt;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_slot
    layer_slot_fsm u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_token      (r_token[k]),
      .i_busy       (i_layer_busy[k]),
      .i_done       (i_layer_done[k]),
      .i_next_busy  (o_next_busy[k]),
      .o_take       (w_take[k]),
      .o_start      (o_start[k]),
      .o_func_start (o_func_start[k]),
      .o_done_ok    (w_done_ok[k]),
      .o_state      (w_state[k])
    );

    assign w_occ[k] = is_occupied(r_token[k], w_state[k]);

    if (k == 0) begin : g_first
      assign w_tok_set[k] = i_in_valid && !w_occ[0];
    end else begin : g_chain
      assign w_tok_set[k] = w_done_ok[k-1];
    end

    if (k == NUM_LAYERS - 1) begin : g_last
      assign o_next_busy[k] = i_out_stall;
    end else begin : g_mid
      assign o_next_busy[k] = w_occ[k+1];
    end
  end

  assign o_in_ready = !w_occ[0];

  // Set wins over consume so a hand-off landing on the cycle the slot leaves IDLE is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_token <= '0;
    end else begin
      r_token <= (r_token & ~w_take) | w_tok_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_img_cnt   <= '0;
    end else begin
      r_out_valid <= w_done_ok[NUM_LAYERS-1];
      if (w_done_ok[NUM_LAYERS-1]) r_img_cnt <= r_img_cnt + CNT_W'(1);
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_img_cnt   = r_img_cnt;

`ifdef LAYER_SCHED_PERF_EN
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_perf
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stall_cnt <= '0;
      end else if ((w_state[k] == ST_FUNC_WAIT) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end

    assign o_stall_cnt[k] = r_stall_cnt;
  end
`endif

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 5, number of chained layers (conv/pool/fc) sequenced.
REQ-002 SHALL have parameter CNT_W, default 16, width of image and performance counters.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_in_valid, input, 1, a new input image is loaded into layer 0's input buffer.
REQ-006 SHALL have port o_in_ready, output, 1, layer 0 can accept an image.
REQ-007 SHALL have port i_layer_busy, input, NUM_LAYERS, per-layer o_busy (CIM phase active).
REQ-008 SHALL have port i_layer_done, input, NUM_LAYERS, per-layer one-cycle pulse at end of function/output phase.
REQ-009 SHALL have port o_start, output, NUM_LAYERS, per-layer one-cycle i_start pulse.
REQ-010 SHALL have port o_func_start, output, NUM_LAYERS, per-layer one-cycle i_func_start pulse.
REQ-011 SHALL have port o_next_busy, output, NUM_LAYERS, per-layer i_next_busy (downstream occupied).
REQ-012 SHALL have port i_out_stall, input, 1, sink cannot accept the last layer's output.
REQ-013 SHALL have port o_out_valid, output, 1, one-cycle pulse when the last layer completes an image.
REQ-014 SHALL have port o_img_cnt, output, CNT_W, completed-image count.

Function
REQ-015 Each layer k SHALL have a token bit and an FSM with states IDLE, CIM_START, CIM_WAIT, FUNC_WAIT, FUNC_RUN.
REQ-016 Token 0 SHALL set on i_in_valid&&o_in_ready; token k+1 SHALL set on i_layer_done[k] while layer k is in FUNC_RUN.
REQ-017 IDLE->CIM_START SHALL occur when token k is set; the token SHALL clear in the same cycle.
REQ-018 CIM_START SHALL drive o_start[k]=1 for exactly one cycle, then go to CIM_WAIT.
REQ-019 CIM_WAIT SHALL record that i_layer_busy[k] was seen high and leave only after it has been seen high and is then sampled low.
REQ-020 FUNC_WAIT SHALL go to FUNC_RUN when o_next_busy[k]==0, pulsing o_func_start[k] for one cycle on that transition.
REQ-021 FUNC_RUN SHALL return to IDLE on i_layer_done[k].
REQ-022 occ(k) SHALL equal token k OR state k != IDLE.
REQ-023 o_next_busy[k] SHALL equal occ(k+1) for k<NUM_LAYERS-1.
REQ-024 o_next_busy[NUM_LAYERS-1] SHALL equal i_out_stall.
REQ-025 o_in_ready SHALL equal !occ(0).
REQ-026 i_in_valid while o_in_ready==0 SHALL be ignored.
REQ-027 Done on the last layer SHALL pulse o_out_valid next cycle and increment o_img_cnt, wrapping at 2^CNT_W-1 -> 0.
REQ-028 i_layer_done[k] outside FUNC_RUN and busy edges outside CIM_WAIT SHALL be ignored.
REQ-029 A done from layer k and layer k+1 leaving IDLE in the same cycle SHALL be legal: the token is consumed then re-set, never lost.
REQ-030 Latency i_in_valid -> o_start[0] SHALL be 2 cycles (token set, then CIM_START).

Reset
REQ-031 rst low SHALL force all FSMs to IDLE, clear tokens and counters, and drive o_start=0, o_func_start=0, o_out_valid=0, o_img_cnt=0, o_in_ready=1 and o_next_busy=i_out_stall on the last bit and 0 elsewhere; in-flight images SHALL be discarded.

Configuration
REQ-032 With LAYER_SCHED_PERF_EN defined, the block SHALL add output o_stall_cnt[NUM_LAYERS][CNT_W], counting cycles each layer spends in FUNC_WAIT, saturating and cleared by reset.
REQ-033 Without LAYER_SCHED_PERF_EN, o_stall_cnt and its logic SHALL be absent, with identical scheduling behaviour.

Structure
REQ-034 The state enum (layer_state_t) and the default CNT_W SHALL live in shared package cim_sched_pkg.
REQ-035 The per-layer FSM SHALL be one sub-module, layer_slot_fsm, instantiated NUM_LAYERS times by generate.

Verification
REQ-036 Single image, no stalls: i_in_valid at cycle 0 -> o_start[0] at cycle 2; each layer runs in order; one o_out_valid; o_img_cnt=1.
REQ-037 Back-pressure: i_out_stall=1 while layer 4 is in FUNC_WAIT -> no o_func_start[4]; after deassert -> pulse next cycle; o_next_busy[3]=1 throughout.
REQ-038 Pipelining: 3 back-to-back images -> layers 0 and 1 are active concurrently; 3 o_out_valid pulses in order; o_img_cnt=3.
REQ-039 Spurious input: i_layer_done[2] pulsed while layer 2 is IDLE -> no state or token change; i_in_valid with o_in_ready=0 -> dropped.
REQ-040 Reset mid-operation: rst low while layer 1 is in CIM_WAIT -> all outputs reach their reset values asynchronously; o_in_ready=1 after release.
REQ-041 With LAYER_SCHED_PERF_EN: hold i_out_stall for 10 cycles in FUNC_WAIT -> o_stall_cnt[4]=10.
